adc_spi_responder: RTL and testbench

SPI target that emulates the 8-channel, 12-bit serial ADC on the oscilloscope's acquisition interface. It sits on the far side of the ADC link, facing the on-chip SPI master: it samples `cs`, `sclk` and `din`, decodes the 3-bit channel address, and serialises a 12-bit sample on `dout`. It is used for loopback bring-up and closed-loop verification of the acquisition path without the physical converter. All logic runs on one system clock that oversamples `sclk`.

---
 rtl/adc_spi_responder.sv | 160 ++++++++++++++++
 tb/tb_adc_spi_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// SPI target emulating an 8-channel 12-bit serial ADC. It oversamples sclk/cs/din on clk,
// decodes the 3-bit channel address, and returns the channel selected in the previous frame.
//
//  state  | meaning
//  IDLE   | cs high: bit counter held at 0, dout driven 0
//  ACTIVE | cs low: counting sclk cycles, decoding the address, shifting the sample out
module adc_spi_responder #(
    parameter int DW  = 12,
    parameter int NCH = 8
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   din,
    input  logic [NCH*DW-1:0]      ch_data,
    output logic                   dout,
    output logic                   frame_done,
    output logic [$clog2(NCH)-1:0] last_addr,
    output logic [DW-1:0]          last_sample,
    output logic                   frame_err
);
    localparam int         AW       = $clog2(NCH);
    localparam logic [4:0] LAST_BIT = 5'(DW + 4);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sclk_sync_q, sclk_sync_d;
    logic [2:0]      cs_sync_q, cs_sync_d;
    logic [2:0]      din_sync_q, din_sync_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            cs_fall_q, cs_fall_d;
    logic            cs_rise_q, cs_rise_d;
    logic [4:0]      bitn_q, bitn_d;
    logic            rise16_q, rise16_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [AW-1:0]   act_addr_q, act_addr_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic            dout_q, dout_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic [DW-1:0]   last_sample_q, last_sample_d;
    logic [4:0]      next_bitn;
    logic [3:0]      sh_idx;

    always_comb begin
        state_d       = state_q;
        bitn_d        = bitn_q;
        rise16_d      = rise16_q;
        pend_addr_d   = pend_addr_q;
        act_addr_d    = act_addr_q;
        shreg_d       = shreg_q;
        dout_d        = dout_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        last_addr_d   = last_addr_q;
        last_sample_d = last_sample_q;

        // [0],[1] synchronise; [2] is the previous value for edge detection
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[1:0], cs};
        din_sync_d  = {din_sync_q[1:0], din};
        rise_d      =  sclk_sync_q[1] & ~sclk_sync_q[2];
        fall_d      = ~sclk_sync_q[1] &  sclk_sync_q[2];
        cs_fall_d   = ~cs_sync_q[1]   &  cs_sync_q[2];
        cs_rise_d   =  cs_sync_q[1]   & ~cs_sync_q[2];

        next_bitn = (bitn_q == LAST_BIT) ? 5'd1 : bitn_q + 5'd1;
        sh_idx    = 4'(LAST_BIT - next_bitn);

        case (state_q)
            IDLE: begin
                bitn_d   = 5'd0;
                dout_d   = 1'b0;
                rise16_d = 1'b0;
                if (cs_fall_q) begin
                    state_d = ACTIVE;
                    if (fall_q) bitn_d = 5'd1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                    bitn_d  = 5'd0;
                    dout_d  = 1'b0;
                    // rise16 is clear from the cycle-16 fall until its rising edge
                    if (bitn_q != 5'd0 && !rise16_q) frame_err_d = 1'b1;
                end else if (fall_q) begin
                    bitn_d   = next_bitn;
                    rise16_d = 1'b0;
                    if (next_bitn == 5'd4) shreg_d = ch_data[int'(act_addr_q)*DW +: DW];
                    dout_d = (next_bitn >= 5'd5) ? shreg_q[sh_idx] : 1'b0;
                end else if (rise_q) begin
                    if (bitn_q >= 5'd3 && int'(bitn_q) < 3 + AW) begin
                        pend_addr_d[AW-1-(int'(bitn_q)-3)] = din_sync_q[2];
                    end else if (bitn_q == LAST_BIT && !rise16_q) begin
                        rise16_d      = 1'b1;
                        frame_done_d  = 1'b1;
                        act_addr_d    = pend_addr_q;
                        last_addr_d   = pend_addr_q;
                        last_sample_d = shreg_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            sclk_sync_q   <= '0;
            cs_sync_q     <= '0;
            din_sync_q    <= '0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            cs_fall_q     <= 1'b0;
            cs_rise_q     <= 1'b0;
            bitn_q        <= '0;
            rise16_q      <= 1'b0;
            pend_addr_q   <= '0;
            act_addr_q    <= '0;
            shreg_q       <= '0;
            dout_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            last_addr_q   <= '0;
            last_sample_q <= '0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            din_sync_q    <= din_sync_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            cs_fall_q     <= cs_fall_d;
            cs_rise_q     <= cs_rise_d;
            bitn_q        <= bitn_d;
            rise16_q      <= rise16_d;
            pend_addr_q   <= pend_addr_d;
            act_addr_q    <= act_addr_d;
            shreg_q       <= shreg_d;
            dout_q        <= dout_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            last_addr_q   <= last_addr_d;
            last_sample_q <= last_sample_d;
        end
    end

    assign dout        = dout_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign last_addr   = last_addr_q;
    assign last_sample = last_sample_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: an SPI master model drives frames, a scoreboard queue holds the
// expected address/sample per frame and a monitor checks them on every frame_done pulse.
module tb_adc_spi_responder;
    typedef struct packed {
        logic [2:0]  a;
        logic [11:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        sclk = 1'b1;
    logic        cs = 1'b1;
    logic        din = 1'b0;
    logic [95:0] ch_data;
    logic [11:0] ch [8];
    logic        dout, frame_done, frame_err;
    logic [2:0]  last_addr;
    logic [11:0] last_sample;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [2:0]  act = 3'd0;

    adc_spi_responder #(.DW(12), .NCH(8)) dut (
        .clk(clk), .Reset(Reset), .sclk(sclk), .cs(cs), .din(din), .ch_data(ch_data),
        .dout(dout), .frame_done(frame_done), .last_addr(last_addr),
        .last_sample(last_sample), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = ch[i];
    end

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endfunction

    always @(negedge clk) begin
        if (!Reset) begin
            if (frame_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_done: got addr %0d sample %h required no frame",
                             last_addr, last_sample);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("last_addr", 32'(last_addr), 32'(e.a));
                    chk("last_sample", 32'(last_sample), 32'(e.s));
                end
            end
            if (frame_err) err_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    // Drives ncyc sclk cycles starting from the falling edge; dout is captured on each rising edge.
    task automatic run_bits(input logic [2:0] addr, input int ncyc, input logic chg_en,
                            input int chg_ch, input logic [11:0] chg_val, output logic [15:0] rx);
        rx = '0;
        for (int c = 1; c <= ncyc; c++) begin
            sclk = 1'b0;
            din  = (c == 3) ? addr[2] : (c == 4) ? addr[1] : (c == 5) ? addr[0] : 1'b0;
            if (chg_en && c == 4) begin
                // capture happens 3.5 clk after this edge; change half a clk later
                repeat (4) @(negedge clk);
                ch[chg_ch] = chg_val;
                repeat (2) @(negedge clk);
            end else begin
                half();
            end
            sclk = 1'b1;
            rx = {rx[14:0], dout};
            half();
        end
    endtask

    task automatic frame(input logic [2:0] addr, input string nm, input logic chg_en,
                         input int chg_ch, input logic [11:0] chg_val);
        logic [15:0] rx;
        logic [11:0] req;
        req = ch[act];
        sb.push_back('{a: addr, s: req});
        cs = 1'b0;
        half();
        run_bits(addr, 16, chg_en, chg_ch, chg_val, rx);
        half();
        cs = 1'b1;
        half();
        half();
        chk(nm, 32'(rx), 32'({4'b0, req}));
        act = addr;
    endtask

    initial begin
        logic [15:0] rx;
        logic [2:0]  caddr [4];
        int          d0;
        ch[0] = 12'hA5C; ch[1] = 12'h3C1; ch[2] = 12'h0F0; ch[3] = 12'h123;
        ch[4] = 12'h7E5; ch[5] = 12'h9AB; ch[6] = 12'h456; ch[7] = 12'hFFF;
        caddr[0] = 3'd1; caddr[1] = 3'd2; caddr[2] = 3'd7; caddr[3] = 3'd0;

        repeat (4) @(negedge clk);
        Reset = 1'b0;
        half();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_last_addr", 32'(last_addr), 32'd0);
        chk("rst_last_sample", 32'(last_sample), 32'd0);

        // basic read, then pipelined address selection
        frame(3'd3, "basic_dout", 1'b0, 0, 12'h0);
        chk("basic_dout_word", 32'(16'h0A5C), 32'(16'h0A5C) ^ 32'(last_sample ^ 12'hA5C));
        frame(3'd5, "pipe2_dout", 1'b0, 0, 12'h0);
        frame(3'd0, "pipe3_dout", 1'b0, 0, 12'h0);
        chk("frames_done_3", 32'(done_cnt), 32'd3);

        // four back-to-back frames under one cs assertion
        cs = 1'b0;
        half();
        for (int k = 0; k < 4; k++) begin
            logic [11:0] req;
            req = ch[act];
            sb.push_back('{a: caddr[k], s: req});
            run_bits(caddr[k], 16, 1'b0, 0, 12'h0, rx);
            chk("cont_dout", 32'(rx), 32'({4'b0, req}));
            act = caddr[k];
        end
        half();
        cs = 1'b1;
        half();
        half();
        chk("cont_done", 32'(done_cnt), 32'd7);
        chk("cont_no_err", 32'(err_cnt), 32'd0);

        // abort after cycle 9: error pulse, selection unchanged
        cs = 1'b0;
        half();
        run_bits(3'd6, 9, 1'b0, 0, 12'h0, rx);
        cs = 1'b1;
        half();
        half();
        chk("abort_err", 32'(err_cnt), 32'd1);
        chk("abort_no_done", 32'(done_cnt), 32'd7);
        frame(3'd4, "after_abort_dout", 1'b0, 0, 12'h0);

        // abort after the cycle-16 fall but before its rising edge
        cs = 1'b0;
        half();
        run_bits(3'd1, 15, 1'b0, 0, 12'h0, rx);
        sclk = 1'b0;
        half();
        cs = 1'b1;
        half();
        sclk = 1'b1;
        half();
        half();
        chk("abort16_err", 32'(err_cnt), 32'd2);
        chk("abort16_no_done", 32'(done_cnt), 32'd8);

        // ch_data changes just after the capture point: old value is returned
        frame(3'd2, "capture_dout", 1'b1, 4, 12'h111);

        // reset during cycle 7 with cs held low
        cs = 1'b0;
        half();
        run_bits(3'd5, 6, 1'b0, 0, 12'h0, rx);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        act = 3'd0;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_last_addr", 32'(last_addr), 32'd0);
        chk("mid_rst_last_sample", 32'(last_sample), 32'd0);
        d0 = done_cnt;
        run_bits(3'd5, 9, 1'b0, 0, 12'h0, rx);
        chk("post_rst_quiet_dout", 32'(rx), 32'd0);
        chk("post_rst_quiet_done", 32'(done_cnt), 32'(d0));
        chk("post_rst_quiet_err", 32'(err_cnt), 32'd2);
        cs = 1'b1;
        half();
        half();
        frame(3'd3, "post_rst_dout", 1'b0, 0, 12'h0);

        chk("total_done", 32'(done_cnt), 32'd10);
        chk("total_err", 32'(err_cnt), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("idle_dout", 32'(dout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
